// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: read response codes and the read-master state type.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    RRESP_OKAY   = 2'b00,
    RRESP_EXOKAY = 2'b01,
    RRESP_SLVERR = 2'b10,
    RRESP_DECERR = 2'b11
  } rresp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_RESP = 2'b11
  } rd_state_e;

  localparam logic [2:0] ARPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi4_lite_read_master.sv
// Single-outstanding AXI4-Lite read master: one core request becomes one AR/R
// handshake pair and a one-cycle response pulse back to the core.
module axi4_lite_read_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  rd_state_e             state_q;
  rd_state_e             state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  rresp_e                resp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = req_valid     ? ST_ADDR : ST_IDLE;
      ST_ADDR: state_d = M_AXI_ARREADY ? ST_DATA : ST_ADDR;
      ST_DATA: state_d = M_AXI_RVALID  ? ST_RESP : ST_DATA;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The address register only loads in IDLE, so ARADDR cannot move while ARVALID waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else if (state_q == ST_IDLE && req_valid) begin
      addr_q <= req_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      resp_q <= RRESP_OKAY;
    end else if (state_q == ST_DATA && M_AXI_RVALID) begin
      data_q <= M_AXI_RDATA;
      resp_q <= rresp_e'(M_AXI_RRESP);
    end
  end

  // Moore outputs: every handshake signal is a pure function of the state.
  always_comb begin
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_err      = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    case (state_q)
      ST_IDLE: req_ready     = 1'b1;
      ST_ADDR: M_AXI_ARVALID = 1'b1;
      ST_DATA: M_AXI_RREADY  = 1'b1;
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = (resp_q == RRESP_SLVERR) || (resp_q == RRESP_DECERR);
      end
      default: req_ready = 1'b0;
    endcase
  end

  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_ARPROT = ARPROT_DEFAULT;
  assign resp_data    = data_q;

endmodule
